dest_reg_decoder: RTL and testbench
===================================

Name: dest_reg_decoder

Overview:
- Destination-side counterpart of the 3-bit register-index select path in the multi-cycle CPU.
- Decodes a 3-bit destination index into a one-hot write strobe and writes an 8-entry register bank.
- Keeps a pending (scoreboard) bit per register between allocation and write-back.
- Provides two registered read ports with write-through bypass, for the decode/operand-fetch stage.

Parameters:
- DATA_W, 16, width of each register and of the write-back data.
- NREG, 8, number of registers. Fixed by the 3-bit index; must equal 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- alloc_valid  input  1  destination allocation strobe (issue stage)
- alloc_addr  input  3  destination index being allocated
- wb_valid  input  1  write-back strobe
- wb_addr  input  3  write-back destination index
- wb_data  input  DATA_W  write-back value
- rd_addr_a  input  3  read port A index
- rd_addr_b  input  3  read port B index
- rd_data_a  output  DATA_W  registered read data A
- rd_data_b  output  DATA_W  registered read data B
- rd_pend_a  output  1  registered pending flag for rd_addr_a
- rd_pend_b  output  1  registered pending flag for rd_addr_b
- we_onehot  output  8  registered one-hot write strobe, one cycle after a wb_valid
- pending  output  8  scoreboard vector, bit i set means register i awaits write-back
- wb_err  output  1  one-cycle pulse: write-back to a register that was not pending

Behaviour:
- Reset: asynchronous on rst_n low. All registers, rd_data_a/b, rd_pend_a/b, we_onehot, pending and wb_err go to 0. All outputs are registered and update only on rising clk.
- Write: on a clk edge with wb_valid=1, reg[wb_addr] <= wb_data.
  - we_onehot <= 1<<wb_addr; otherwise we_onehot <= 0.
  - we_onehot is observability only; the bank write is not delayed by it.
- Scoreboard, evaluated per bit i each edge:
  - set term: alloc_valid && alloc_addr==i.
  - clear term: wb_valid && wb_addr==i.
  - Set wins over clear, so same-cycle alloc and write-back to the same index leaves the bit at 1. The new producer owns the register.
- wb_err: wb_err <= wb_valid && !pending[wb_addr], using the pre-edge pending value. The write is still performed.
- Reads: 1-cycle latency.
  - rd_data_x <= (wb_valid && wb_addr==rd_addr_x) ? wb_data : reg[rd_addr_x] (write-through bypass).
  - rd_pend_x <= next-state pending bit for rd_addr_x, after applying the same-edge set/clear.
- Read ports are independent; both may address the same register.
- Back-to-back write-backs to one index: the last value wins; each write produces its own we_onehot pulse.
- Allocating an already-pending register: the bit stays 1. No error, no counting (single outstanding producer per register).
- Reset mid-operation: all pending writes are abandoned and the scoreboard is cleared. No write from the reset cycle is retained.

Optional Feature:
- Macro: DEST_REG_R0_ZERO_EN.
- When defined, register 0 is hardwired zero:
  - writes to index 0 are dropped; we_onehot bit 0 never asserts.
  - pending[0] stays 0; rd_data for index 0 reads 0 with no bypass; rd_pend for index 0 reads 0.
  - wb_err is never raised for index 0.
- When undefined, index 0 behaves like any other register.

Test Plan:
- Reset check: rst_n low mid-cycle with pending=8'hFF -> pending, we_onehot, rd_data_a/b, wb_err are 0 immediately, without waiting for a clk edge.
- Allocate then write:
  - alloc_addr=3 -> pending=8'h08 next cycle.
  - wb_addr=3, wb_data=16'hBEEF -> pending=8'h00, we_onehot=8'h08 for one cycle.
  - rd_addr_a=3 -> rd_data_a=16'hBEEF, rd_pend_a=0.
- Bypass: wb_addr=5, wb_data=16'h1234 and rd_addr_b=5 on the same edge -> rd_data_b=16'h1234 on the next cycle.
- Simultaneous set/clear: reg 6 pending; alloc_addr=6 and wb_addr=6 on the same edge -> pending[6] stays 1, reg6 updated, wb_err=0.
- Spurious write-back: wb_addr=2 with pending[2]=0 -> wb_err pulses for exactly one cycle, reg2 written.
- Macro build with DEST_REG_R0_ZERO_EN: alloc_addr=0, then wb_addr=0, wb_data=16'hFFFF -> pending[0]=0, we_onehot=0, rd_data_a (rd_addr_a=0)=0, wb_err=0.

Source files
------------

// File: rtl/dest_reg_decoder.sv
// Destination register bank with one-hot write strobe, pending scoreboard and two bypassed read ports.
// Optional build macro DEST_REG_R0_ZERO_EN hardwires register 0 to zero.
module dest_reg_decoder #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [2:0]        alloc_addr,
    input  logic              wb_valid,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_pend_a,
    output logic              rd_pend_b,
    output logic [7:0]        we_onehot,
    output logic [7:0]        pending,
    output logic              wb_err
);

    logic [DATA_W-1:0] bank_q [NREG];
    logic [DATA_W-1:0] bank_d [NREG];
    logic [NREG-1:0]   pending_q, pending_d;
    logic [NREG-1:0]   we_onehot_q, we_onehot_d;
    logic [NREG-1:0]   set_vec, clr_vec;
    logic              wb_err_q, wb_err_d;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              rd_pend_a_q, rd_pend_a_d;
    logic              rd_pend_b_q, rd_pend_b_d;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (alloc_valid) set_vec[alloc_addr] = 1'b1;
        if (wb_valid)    clr_vec[wb_addr]    = 1'b1;
`ifdef DEST_REG_R0_ZERO_EN
        // Index 0 is inert: never allocated, never written, never flagged.
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
`endif
        // Set dominates clear so a re-allocating producer keeps ownership.
        pending_d   = set_vec | (pending_q & ~clr_vec);
        we_onehot_d = clr_vec;
        wb_err_d    = |(clr_vec & ~pending_q);

        for (int i = 0; i < NREG; i++) begin
            bank_d[i] = clr_vec[i] ? wb_data : bank_q[i];
        end

        rd_data_a_d = clr_vec[rd_addr_a] ? wb_data : bank_q[rd_addr_a];
        rd_data_b_d = clr_vec[rd_addr_b] ? wb_data : bank_q[rd_addr_b];
        rd_pend_a_d = pending_d[rd_addr_a];
        rd_pend_b_d = pending_d[rd_addr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
            pending_q   <= '0;
            we_onehot_q <= '0;
            wb_err_q    <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                bank_q[i] <= bank_d[i];
            end
            pending_q   <= pending_d;
            we_onehot_q <= we_onehot_d;
            wb_err_q    <= wb_err_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_pend_a_q <= rd_pend_a_d;
            rd_pend_b_q <= rd_pend_b_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_pend_a = rd_pend_a_q;
    assign rd_pend_b = rd_pend_b_q;
    assign we_onehot = we_onehot_q;
    assign pending   = pending_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_dest_reg_decoder.sv
// Randomized bench for dest_reg_decoder against an array-based model of the register bank and scoreboard.
module tb_dest_reg_decoder;

`ifdef DEST_REG_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, wb_valid;
    logic [2:0]  alloc_addr, wb_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wb_data;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_pend_a, rd_pend_b, wb_err;
    logic [7:0]  we_onehot, pending;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_reg [8];
    logic [7:0]  m_pend;

    dest_reg_decoder #(.DATA_W(16), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b),
        .we_onehot(we_onehot), .pending(pending), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_pend = '0;
    endtask

    // One clock: predict from current inputs, clock, then compare every output.
    task automatic cycle();
        logic [15:0] nr [8];
        logic [7:0]  np;
        logic [7:0]  e_we;
        logic        e_err;
        logic [15:0] e_rda, e_rdb;
        logic        e_pa, e_pb;
        for (int i = 0; i < 8; i++) nr[i] = m_reg[i];
        np    = m_pend;
        e_we  = '0;
        e_err = 1'b0;
        if (wb_valid && !(R0Z && wb_addr == 3'd0)) begin
            e_we          = 8'(1 << wb_addr);
            e_err         = !m_pend[wb_addr];
            nr[wb_addr]   = wb_data;
            np[wb_addr]   = 1'b0;
        end
        if (alloc_valid && !(R0Z && alloc_addr == 3'd0)) np[alloc_addr] = 1'b1;
        e_rda = nr[rd_addr_a];
        e_rdb = nr[rd_addr_b];
        e_pa  = np[rd_addr_a];
        e_pb  = np[rd_addr_b];
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) m_reg[i] = nr[i];
        m_pend = np;
        chk("pending",   32'(pending),   32'(np));
        chk("we_onehot", 32'(we_onehot), 32'(e_we));
        chk("wb_err",    32'(wb_err),    32'(e_err));
        chk("rd_data_a", 32'(rd_data_a), 32'(e_rda));
        chk("rd_data_b", 32'(rd_data_b), 32'(e_rdb));
        chk("rd_pend_a", 32'(rd_pend_a), 32'(e_pa));
        chk("rd_pend_b", 32'(rd_pend_b), 32'(e_pb));
    endtask

    // Asynchronous reset dropped mid-cycle; outputs must clear before any edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_pending"},   32'(pending),   32'h0);
        chk({tag, "_we_onehot"}, 32'(we_onehot), 32'h0);
        chk({tag, "_rd_data_a"}, 32'(rd_data_a), 32'h0);
        chk({tag, "_rd_data_b"}, 32'(rd_data_b), 32'h0);
        chk({tag, "_wb_err"},    32'(wb_err),    32'h0);
        model_clear();
        alloc_valid = 1'b1;
        alloc_addr  = 3'd1;
        wb_valid    = 1'b1;
        wb_addr     = 3'd1;
        wb_data     = 16'hDEAD;
        @(posedge clk);
        #1;
        chk({tag, "_held_pending"}, 32'(pending), 32'h0);
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        idle();
        alloc_addr = '0;
        wb_addr    = '0;
        wb_data    = '0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pending", 32'(pending),   32'h0);
        chk("reset_rd_a",    32'(rd_data_a), 32'h0);
        rst_n = 1'b1;

        // Allocate then write-back register 3
        alloc_valid = 1'b1; alloc_addr = 3'd3;
        cycle();
        chk("alloc3_pending", 32'(pending), 32'h08);
        idle();
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF; rd_addr_a = 3'd3;
        cycle();
        chk("wb3_pending",   32'(pending),   32'h00);
        chk("wb3_we",        32'(we_onehot), 32'h08);
        chk("wb3_rd_a",      32'(rd_data_a), 32'hBEEF);
        chk("wb3_rd_pend_a", 32'(rd_pend_a), 32'h0);
        chk("wb3_err",       32'(wb_err),    32'h0);
        idle();
        cycle();
        chk("wb3_we_drop",   32'(we_onehot), 32'h00);
        chk("wb3_rd_a_hold", 32'(rd_data_a), 32'hBEEF);

        // Same-edge bypass on port B
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234; rd_addr_b = 3'd5;
        cycle();
        chk("bypass_rd_b", 32'(rd_data_b), 32'h1234);
        idle();

        // Simultaneous set and clear on register 6
        alloc_valid = 1'b1; alloc_addr = 3'd6;
        cycle();
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'hABCD; rd_addr_a = 3'd6;
        cycle();
        chk("setclr_pend6", 32'(pending[6]), 32'h1);
        chk("setclr_err",   32'(wb_err),     32'h0);
        chk("setclr_rd_a",  32'(rd_data_a),  32'hABCD);
        chk("setclr_pa",    32'(rd_pend_a),  32'h1);
        idle();

        // Spurious write-back to register 2
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h5555; rd_addr_b = 3'd2;
        cycle();
        chk("spur_err",  32'(wb_err), 32'h1);
        idle();
        cycle();
        chk("spur_err_drop", 32'(wb_err),    32'h0);
        chk("spur_rd_b",     32'(rd_data_b), 32'h5555);

        // Register 0 behaviour
        alloc_valid = 1'b1; alloc_addr = 3'd0;
        cycle();
        idle();
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF; rd_addr_a = 3'd0;
        cycle();
        idle();
`ifdef DEST_REG_R0_ZERO_EN
        chk("r0_pend", 32'(pending[0]), 32'h0);
        chk("r0_we",   32'(we_onehot),  32'h00);
        chk("r0_rd_a", 32'(rd_data_a),  32'h0);
        chk("r0_err",  32'(wb_err),     32'h0);
`else
        chk("r0_pend", 32'(pending[0]), 32'h0);
        chk("r0_we",   32'(we_onehot),  32'h01);
        chk("r0_rd_a", 32'(rd_data_a),  32'hFFFF);
        chk("r0_err",  32'(wb_err),     32'h0);
`endif

        // Back-to-back write-backs to register 4
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h1111; rd_addr_b = 3'd4;
        cycle();
        chk("b2b_we1", 32'(we_onehot), 32'h10);
        wb_data = 16'h2222;
        cycle();
        chk("b2b_we2",  32'(we_onehot), 32'h10);
        chk("b2b_rd_b", 32'(rd_data_b), 32'h2222);
        idle();
        cycle();

        // Fill the scoreboard, then reset mid-cycle
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_addr = 3'(i);
            cycle();
        end
        idle();
        chk("fill_pending", 32'(pending), R0Z ? 32'hFE : 32'hFF);
        mid_reset("rst_full");
        cycle();

        // Randomized traffic with occasional mid-operation resets
        for (int n = 0; n < 3000; n++) begin
            alloc_valid = ($urandom_range(0, 1) == 1);
            alloc_addr  = 3'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 2) != 0);
            wb_addr     = ($urandom_range(0, 3) == 0) ? alloc_addr : 3'($urandom_range(0, 7));
            wb_data     = 16'($urandom);
            rd_addr_a   = ($urandom_range(0, 2) == 0) ? wb_addr : 3'($urandom_range(0, 7));
            rd_addr_b   = ($urandom_range(0, 2) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            cycle();
            if ($urandom_range(0, 299) == 0) begin
                idle();
                mid_reset("rst_rand");
            end
        end
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
